// File: rtl/decode_pkg.sv
// Shared types and field layout for the instruction-decode stage.
// decode_instr() slices a raw instruction word into a decoded_t record.
package decode_pkg;

    localparam int DEC_IW   = 32;
    localparam int DEC_REGW = 6;
    localparam int DEC_FXW  = 4;

    // Field offsets, MSB down: ri | rs | rd | fx | LOW
    localparam int RI_POS  = DEC_IW - 1;
    localparam int RS_LSB  = RI_POS - DEC_REGW;
    localparam int RD_LSB  = RS_LSB - DEC_REGW;
    localparam int FX_LSB  = RD_LSB - DEC_FXW;
    localparam int LOW_W   = FX_LSB;
    localparam int RT_LSB  = LOW_W - DEC_REGW;
    localparam int RIMM_W  = RT_LSB;

    typedef struct packed {
        logic                ri;
        logic [DEC_REGW-1:0] rs;
        logic [DEC_REGW-1:0] rd;
        logic [DEC_FXW-1:0]  fx;
        logic [DEC_REGW-1:0] rt;
        logic [DEC_IW-1:0]   imm;
        logic                illegal;
    } decoded_t;

    function automatic decoded_t decode_instr(
        input logic [DEC_IW-1:0]       instr,
        input logic                    imm_signed,
        input logic [2**DEC_FXW-1:0]   fx_legal
    );
        decoded_t d;
        logic     ext;
        d.ri = instr[RI_POS];
        d.rs = instr[RS_LSB +: DEC_REGW];
        d.rd = instr[RD_LSB +: DEC_REGW];
        d.fx = instr[FX_LSB +: DEC_FXW];
        if (d.ri) begin
            d.rt  = '0;
            ext   = imm_signed & instr[LOW_W-1];
            d.imm = {{(DEC_IW-LOW_W){ext}}, instr[LOW_W-1:0]};
        end else begin
            // R-type: rt occupies the top of LOW, the shorter immediate the rest
            d.rt  = instr[RT_LSB +: DEC_REGW];
            ext   = imm_signed & instr[RIMM_W-1];
            d.imm = {{(DEC_IW-RIMM_W){ext}}, instr[RIMM_W-1:0]};
        end
        d.illegal = ~fx_legal[d.fx];
        return d;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// DEPTH-entry buffer of decoded records with synchronous flush.
// The head reads as zero while the buffer is empty.
module decode_fifo
    import decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_flush,
    input  logic     i_push,
    input  decoded_t i_data,
    input  logic     i_pop,
    output decoded_t o_head,
    output logic     o_empty,
    output logic     o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    decoded_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage: decodes in_instr combinationally and
// buffers the decoded records in a small FIFO towards register-file/ALU issue.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int                IW         = 32,
    parameter int                REGW       = 6,
    parameter int                FXW        = 4,
    parameter int                DEPTH      = 2,
    parameter int                IMM_SIGNED = 1,
    parameter logic [2**FXW-1:0] FX_LEGAL   = 16'hFFFF,
    parameter int                CNTW       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [IW-1:0]   in_instr,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_ri,
    output logic [REGW-1:0] out_rs,
    output logic [REGW-1:0] out_rd,
    output logic [FXW-1:0]  out_fx,
    output logic [REGW-1:0] out_rt,
    output logic [IW-1:0]   out_imm,
    output logic            out_illegal,
    output logic [CNTW-1:0] decoded_count
);

    if (!(2*REGW + FXW + 1 < IW - REGW)) begin : g_bad_layout
        $error("instr_decode_stage: fields do not fit in IW");
    end
    if (IW != DEC_IW || REGW != DEC_REGW || FXW != DEC_FXW) begin : g_bad_widths
        $error("instr_decode_stage: IW/REGW/FXW must match decode_pkg");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_decode_stage: DEPTH must be a power of two >= 2");
    end

    // Handshake: a transfer happens on a side exactly in the cycle where its
    // valid and ready are both high; in_ready depends on registered state only.
    decoded_t        w_dec;
    decoded_t        w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [CNTW-1:0] r_decoded_count;

    assign w_dec  = decode_instr(in_instr, IMM_SIGNED != 0, FX_LEGAL);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    decode_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_dec),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_decoded_count <= '0;
        end else if (w_push) begin
            r_decoded_count <= r_decoded_count + CNTW'(1);
        end
    end

    assign decoded_count = r_decoded_count;
    assign out_ri        = w_head.ri;
    assign out_rs        = w_head.rs;
    assign out_rd        = w_head.rd;
    assign out_fx        = w_head.fx;
    assign out_rt        = w_head.rt;
    assign out_imm       = w_head.imm;
    assign out_illegal   = w_head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: a default instance plus one with
// zero-extension, a restricted FX_LEGAL mask and a 4-bit counter.
module tb_instr_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, out_valid, out_ri, out_illegal;
    logic [5:0]  out_rs, out_rd, out_rt;
    logic [3:0]  out_fx;
    logic [31:0] out_imm;
    logic [15:0] decoded_count;

    logic        in_ready2, out_valid2, out_ri2, out_illegal2;
    logic [5:0]  out_rs2, out_rd2, out_rt2;
    logic [3:0]  out_fx2;
    logic [31:0] out_imm2;
    logic [3:0]  decoded_count2;

    int n_checks = 0;
    int n_errors = 0;

    instr_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_instr      (in_instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ri        (out_ri),
        .out_rs        (out_rs),
        .out_rd        (out_rd),
        .out_fx        (out_fx),
        .out_rt        (out_rt),
        .out_imm       (out_imm),
        .out_illegal   (out_illegal),
        .decoded_count (decoded_count)
    );

    instr_decode_stage #(
        .IMM_SIGNED (0),
        .FX_LEGAL   (16'h00FF),
        .CNTW       (4)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_instr      (in_instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready2),
        .out_valid     (out_valid2),
        .out_ready     (out_ready),
        .out_ri        (out_ri2),
        .out_rs        (out_rs2),
        .out_rd        (out_rd2),
        .out_fx        (out_fx2),
        .out_rt        (out_rt2),
        .out_imm       (out_imm2),
        .out_illegal   (out_illegal2),
        .decoded_count (decoded_count2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        ri;
        logic [5:0]  rs;
        logic [5:0]  rd;
        logic [3:0]  fx;
        logic [5:0]  rt;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic        ill2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h8629_7FFF, 1'b1, 6'd3,  6'd5,  4'd2,  6'd0,  32'hFFFF_FFFF, 32'h0000_7FFF, 1'b0};
        vecs[1] = '{32'h0212_0FFF, 1'b0, 6'd1,  6'd2,  4'd4,  6'd7,  32'hFFFF_FFFF, 32'h0000_01FF, 1'b0};
        vecs[2] = '{32'h0212_0EFF, 1'b0, 6'd1,  6'd2,  4'd4,  6'd7,  32'h0000_00FF, 32'h0000_00FF, 1'b0};
        vecs[3] = '{32'h8004_8123, 1'b1, 6'd0,  6'd0,  4'd9,  6'd0,  32'h0000_0123, 32'h0000_0123, 1'b1};
        vecs[4] = '{32'h7E07_D500, 1'b0, 6'd63, 6'd0,  4'd15, 6'd42, 32'hFFFF_FF00, 32'h0000_0100, 1'b1};
        vecs[5] = '{32'h81FB_C000, 1'b1, 6'd0,  6'd63, 4'd7,  6'd0,  32'hFFFF_C000, 32'h0000_4000, 1'b0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_instr  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.count", decoded_count, 0);
        chk("rst.out_imm", out_imm, 0);
        rst = 1'b0;

        // Table-driven decode, back-to-back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = vecs[i].instr;
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d.valid", i), out_valid, 1);
            chk($sformatf("vec%0d.ri", i), out_ri, vecs[i].ri);
            chk($sformatf("vec%0d.rs", i), out_rs, vecs[i].rs);
            chk($sformatf("vec%0d.rd", i), out_rd, vecs[i].rd);
            chk($sformatf("vec%0d.fx", i), out_fx, vecs[i].fx);
            chk($sformatf("vec%0d.rt", i), out_rt, vecs[i].rt);
            chk($sformatf("vec%0d.imm_s", i), out_imm, vecs[i].imm_s);
            chk($sformatf("vec%0d.illegal", i), out_illegal, 0);
            chk($sformatf("vec%0d.valid2", i), out_valid2, 1);
            chk($sformatf("vec%0d.imm_u", i), out_imm2, vecs[i].imm_u);
            chk($sformatf("vec%0d.illegal2", i), out_illegal2, vecs[i].ill2);
            chk($sformatf("vec%0d.in_ready", i), in_ready, 1);
        end
        in_valid = 1'b0;
        chk("table.count", decoded_count, 6);
        chk("table.count2", decoded_count2, 6);
        @(negedge clk);
        chk("table.drained", out_valid, 0);

        // Back-pressure: two fill the FIFO, the third waits for a pop
        pulse_reset();
        out_ready = 1'b0;
        in_instr  = 32'h1400_0000;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("bp.a_valid", out_valid, 1);
        chk("bp.a_rs", out_rs, 10);
        chk("bp.ready_after1", in_ready, 1);
        in_instr = 32'h1600_0000;
        @(negedge clk);
        chk("bp.full_ready", in_ready, 0);
        chk("bp.hold_rs1", out_rs, 10);
        in_instr = 32'h1800_0000;
        @(negedge clk);
        chk("bp.still_full", in_ready, 0);
        chk("bp.hold_rs2", out_rs, 10);
        chk("bp.count2", decoded_count, 2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.b_rs", out_rs, 11);
        chk("bp.ready_after_pop", in_ready, 1);
        chk("bp.count_c_pending", decoded_count, 2);
        @(negedge clk);
        chk("bp.c_rs", out_rs, 12);
        chk("bp.c_valid", out_valid, 1);
        chk("bp.count3", decoded_count, 3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.empty", out_valid, 0);
        chk("bp.count_final", decoded_count, 3);

        // Flush mid-stall, then flush colliding with an accept
        out_ready = 1'b0;
        in_instr  = 32'h2800_0000;
        in_valid  = 1'b1;
        @(negedge clk);
        in_instr = 32'h2A00_0000;
        @(negedge clk);
        chk("fl.full", in_ready, 0);
        in_instr = 32'h2C00_0000;
        flush    = 1'b1;
        @(negedge clk);
        chk("fl.valid", out_valid, 0);
        chk("fl.ready", in_ready, 1);
        chk("fl.count", decoded_count, 0);
        in_instr = 32'h2E00_0000;
        @(negedge clk);
        chk("fl.accept_drop_valid", out_valid, 0);
        chk("fl.accept_drop_count", decoded_count, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl.no_ghost_valid", out_valid, 0);
        chk("fl.no_ghost_rs", out_rs, 0);

        // Counter wrap on the 4-bit instance
        pulse_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_instr = 32'(i) << 15;
            @(negedge clk);
            if (i == 15) chk("wrap.count2_16", decoded_count2, 0);
        end
        in_valid = 1'b0;
        chk("wrap.count2_17", decoded_count2, 1);
        chk("wrap.count_17", decoded_count, 17);
        chk("wrap.last_fx", out_fx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the 32-bit processor datapath. It sits between fetch and register-file/ALU issue.
- Splits each instruction word into format bit, rs, rd, fx, rt and immediate fields. It also extends the immediate, flags illegal function codes and buffers results in a small FIFO.
- Valid/ready handshakes on both sides allow back-pressure from the ALU.

Parameters:
- IW, 32, instruction and datapath width in bits.
- REGW, 6, register-specifier width (rs/rd/rt).
- FXW, 4, function-code width.
- DEPTH, 2, output FIFO entries (power of two, >=2).
- IMM_SIGNED, 1, 1 = sign-extend immediates to IW bits, 0 = zero-extend.
- FX_LEGAL, 16'hFFFF, bit k set means fx==k is legal; width 2**FXW.
- CNTW, 16, width of the decoded-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush (drops all buffered entries)
- in_instr  in  IW  raw instruction word
- in_valid  in  1  in_instr is valid
- in_ready  out  1  stage can accept an instruction this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_ri  out  1  format: 1 = I-type, 0 = R-type
- out_rs  out  REGW  source register
- out_rd  out  REGW  destination register
- out_fx  out  FXW  function code
- out_rt  out  REGW  second source register; 0 for I-type
- out_imm  out  IW  extended immediate
- out_illegal  out  1  fx not enabled in FX_LEGAL
- decoded_count  out  CNTW  instructions accepted since reset/flush

Behaviour:
- Field layout, MSB down:
  - ri = [IW-1]
  - rs = next REGW bits
  - rd = next REGW bits
  - fx = next FXW bits
  - LOW = the remaining IW-1-2*REGW-FXW bits (15 by default).
- I-type decode: imm = LOW (15 bits), rt = 0.
- R-type decode: rt = top REGW bits of LOW; imm = the remaining LOW-REGW bits (9 by default).
- Immediate extension: the imm MSB is replicated to IW bits if IMM_SIGNED, else zero-filled.
- Elaboration: static assertion that 2*REGW+FXW+1 < IW-REGW.
- Decode is combinational on in_instr. The decoded record is written into the FIFO on accept (in_valid && in_ready).
- in_ready = (count < DEPTH); it is a function of registered state only.
- When full, no same-cycle pass-through: in_ready=0 even if out_ready=1.
- out_* present the FIFO head whenever out_valid=1 (count>0). Pop on out_valid && out_ready.
- Latency: an instruction accepted at edge N is visible on out_* in the cycle after edge N. Throughput is 1/cycle while out_ready=1.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance, wrapping modulo DEPTH.
- Push into an empty FIFO plus out_ready=1: no pop that cycle, because out_valid was 0.
- out_* hold stable while out_valid && !out_ready.
- decoded_count increments on every accept and wraps from 2**CNTW-1 to 0.
- flush (priority over push/pop): count, pointers and decoded_count go to 0 at the edge; the accept that cycle is discarded and does not count.
- rst has priority over flush. Reset values: out_valid=0, in_ready=1 after the reset edge, decoded_count=0, all out_* data fields 0.
- Reset or flush mid-stall drops the held entry; no output is produced for it.
- out_illegal = !FX_LEGAL[fx]. It is informational only; the entry still flows.

Decomposition:
- Package decode_pkg holds:
  - typedef decoded_t (ri, rs, rd, fx, rt, imm, illegal), parameterised via localparams of IW/REGW/FXW defaults
  - localparams for field offsets
  - function decode_instr() performing the field slicing and extension
- One sub-module, decode_fifo (DEPTH-entry storage of decoded_t with push/pop/flush, count, pointers). instr_decode_stage instantiates it and the decode function.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, in_ready=1, decoded_count=0, out_imm=0.
- I-type: in_instr=32'h8629_7FFF, out_ready=1 -> next cycle out_ri=1, rs=3, rd=5, fx=2, rt=0, imm=32'hFFFF_FFFF; with IMM_SIGNED=0, imm=32'h0000_7FFF.
- R-type: in_instr=32'h0212_0FFF -> ri=0, rs=1, rd=2, fx=4, rt=7, imm=32'hFFFF_FFFF (signed); in_instr=32'h0212_0EFF -> imm=32'h0000_00FF.
- Back-pressure: out_ready=0, push 3 back-to-back -> in_ready drops after 2 accepts, third held; raise out_ready -> entries emerge in order, third accepted the cycle after first pop, decoded_count=3.
- Flush mid-stall: FIFO full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, decoded_count=0, flushed input never appears.
- Illegal/wrap: FX_LEGAL=16'h00FF, fx=9 -> out_illegal=1, entry still delivered; CNTW=4, 17 accepts -> decoded_count=1.
